// File: rtl/overlap_add_stream_pkg.sv
// Shared types and saturation helpers for the overlap/add stage.
package overlap_pkg;

    // Sequence position of a frame; encoding 3 is folded into MIDDLE.
    typedef enum logic [1:0] {
        MIDDLE = 2'd0,
        FIRST  = 2'd1,
        LAST   = 2'd2
    } seq_pos_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        STORE,
        FLUSH
    } state_t;

    // Largest representable value of a signed word of the given width.
    function automatic longint sat_max(int unsigned word);
        return (longint'(1) <<< (word - 1)) - 1;
    endfunction

    // Smallest representable value of a signed word of the given width.
    function automatic longint sat_min(int unsigned word);
        return -(longint'(1) <<< (word - 1));
    endfunction

    function automatic seq_pos_t decode_pos(logic [1:0] raw);
        case (raw)
            2'd1:    return FIRST;
            2'd2:    return LAST;
            default: return MIDDLE;
        endcase
    endfunction

endpackage

// File: rtl/overlap_add_stream_sat_add.sv
// Combinational signed saturating adder with a clamp indicator.
module overlap_sat_add
    import overlap_pkg::*;
#(
    parameter int WORD = 16
) (
    input  logic signed [WORD-1:0] a,
    input  logic signed [WORD-1:0] b,
    output logic signed [WORD-1:0] y,
    output logic                   sat
);

    localparam logic signed [WORD:0] MAX_V = (WORD+1)'(sat_max(WORD));
    localparam logic signed [WORD:0] MIN_V = (WORD+1)'(sat_min(WORD));

    logic signed [WORD:0] sum;

    // One guard bit makes overflow visible; clamp it back into WORD bits.
    always_comb begin
        sum = {a[WORD-1], a} + {b[WORD-1], b};
        y   = sum[WORD-1:0];
        sat = 1'b0;
        if (sum > MAX_V) begin
            y   = MAX_V[WORD-1:0];
            sat = 1'b1;
        end else if (sum < MIN_V) begin
            y   = MIN_V[WORD-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/overlap_add_stream.sv
// Streaming overlap/add: first half of a frame is added to the channel's
// stored history, second half replaces that history, LAST frames flush it.
module overlap_add_stream
    import overlap_pkg::*;
#(
    parameter  int HALF_WINDOW = 512,
    parameter  int WORD        = 16,
    parameter  int CHANNELS    = 2,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [WORD-1:0] in_data,
    input  logic [CW-1:0]          in_ch,
    input  logic [1:0]             in_pos,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [WORD-1:0] out_data,
    output logic [CW-1:0]          out_ch,
    output logic                   out_last,
    output logic                   sat
);

    localparam int             KW     = $clog2(HALF_WINDOW);
    localparam int             DEPTH  = CHANNELS * HALF_WINDOW;
    localparam logic [KW-1:0]  K_LAST = KW'(HALF_WINDOW - 1);

    state_t                 state, state_nxt;
    logic [KW-1:0]          k;
    logic [CW-1:0]          cur_ch;
    seq_pos_t               cur_pos;
    logic signed [WORD-1:0] hist [DEPTH];
    logic [CHANNELS-1:0]    hist_valid;

    logic [CW-1:0]          eff_ch;
    seq_pos_t               eff_pos;
    seq_pos_t               in_pos_dec;
    logic [CW+KW-1:0]       rd_addr;
    logic signed [WORD-1:0] hist_rd;
    logic signed [WORD-1:0] add_b;
    logic signed [WORD-1:0] sum;
    logic                   sum_sat;
    logic                   in_fire;
    logic                   out_fire;
    logic                   k_end;

    assign in_pos_dec = decode_pos(in_pos);
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign k_end      = (k == K_LAST);

    // Sample k=0 is added while still in IDLE, so channel/position come
    // straight from the inputs there and from the latched copies afterwards.
    always_comb begin
        eff_ch  = (state == IDLE) ? in_ch      : cur_ch;
        eff_pos = (state == IDLE) ? in_pos_dec : cur_pos;
        rd_addr = {eff_ch, k};
        hist_rd = hist[rd_addr];
        add_b   = (eff_pos == FIRST || !hist_valid[eff_ch]) ? '0 : hist_rd;
    end

    overlap_sat_add #(.WORD(WORD)) u_sat_add (
        .a   (in_data),
        .b   (add_b),
        .y   (sum),
        .sat (sum_sat)
    );

    // Input acceptance: ADD needs a free output slot, STORE never stalls.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE, ADD: in_ready = !out_valid || out_ready;
                STORE:     in_ready = 1'b1;
                default:   in_ready = 1'b0;
            endcase
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (in_fire) state_nxt = ADD;
            ADD:   if (in_fire && k_end) state_nxt = STORE;
            STORE: if (in_fire && k_end) state_nxt = (cur_pos == LAST) ? FLUSH : IDLE;
            FLUSH: if (out_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counter, frame context, history-valid bits and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            cur_ch     <= '0;
            cur_pos    <= MIDDLE;
            hist_valid <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_last   <= 1'b0;
            sat        <= 1'b0;
        end else begin
            if (out_fire) out_valid <= 1'b0;
            case (state)
                IDLE, ADD: begin
                    if (in_fire) begin
                        if (state == IDLE) begin
                            cur_ch  <= in_ch;
                            cur_pos <= in_pos_dec;
                        end
                        out_valid <= 1'b1;
                        out_data  <= sum;
                        out_ch    <= eff_ch;
                        out_last  <= k_end && (eff_pos != LAST);
                        sat       <= sat | sum_sat;
                        k         <= k + KW'(1);
                    end
                end
                STORE: begin
                    if (in_fire) begin
                        k <= k + KW'(1);
                        if (k_end) hist_valid[cur_ch] <= 1'b1;
                    end
                end
                FLUSH: begin
                    // out_last only appears on the final flush word here,
                    // so its handshake is what ends the flush.
                    if (out_fire && out_last) begin
                        hist_valid[cur_ch] <= 1'b0;
                        out_last           <= 1'b0;
                        k                  <= '0;
                    end else if (!out_valid || out_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= hist_rd;
                        out_ch    <= cur_ch;
                        out_last  <= k_end;
                        k         <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // History storage is deliberately not reset; hist_valid gates its use.
    always_ff @(posedge clk) begin
        if (in_fire && state == STORE) hist[{cur_ch, k}] <= in_data;
    end

endmodule

// File: tb/tb_overlap_add_stream.sv
// Self-checking bench for overlap_add_stream with a frame-level model.
module tb_overlap_add_stream;

    localparam int HW = 4;
    localparam int W  = 16;
    localparam int CH = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
    logic [0:0]          in_ch = '0;
    logic [1:0]          in_pos = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] out_data;
    logic [0:0]          out_ch;
    logic                out_last;
    logic                sat;

    always #5 clk = ~clk;

    overlap_add_stream #(.HALF_WINDOW(HW), .WORD(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_ch(in_ch), .in_pos(in_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .sat(sat)
    );

    typedef struct {
        int data;
        int ch;
        bit last;
        bit sat;
        bit flush;
    } exp_t;

    exp_t expq[$];
    int   cap[$];
    bit   capl[$];
    int   m_hist [CH][HW];
    bit   m_hv [CH];
    bit   m_sat;
    int   checks = 0;
    int   errors = 0;
    int   stall_cycles = 0;
    bit   rnd_ready = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int clampv(int s, output bit c);
        c = 1'b1;
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        c = 1'b0;
        return s;
    endfunction

    function automatic void model_reset();
        expq.delete();
        for (int c = 0; c < CH; c++) m_hv[c] = 1'b0;
        m_sat = 1'b0;
    endfunction

    // Expected output stream of one frame (or its first n samples).
    function automatic void model_frame(int ch, int pos, int s[2*HW], int n);
        bit c;
        int h, v;
        for (int k = 0; k < HW && k < n; k++) begin
            h = (pos == 1 || !m_hv[ch]) ? 0 : m_hist[ch][k];
            v = clampv(s[k] + h, c);
            m_sat = m_sat | c;
            expq.push_back('{v, ch, (k == HW-1 && pos != 2), m_sat, 1'b0});
        end
        if (n == 2*HW) begin
            for (int k = 0; k < HW; k++) m_hist[ch][k] = s[HW+k];
            m_hv[ch] = 1'b1;
            if (pos == 2) begin
                for (int k = 0; k < HW; k++)
                    expq.push_back('{m_hist[ch][k], ch, (k == HW-1), m_sat, 1'b1});
                m_hv[ch] = 1'b0;
            end
        end
    endfunction

    task automatic send(int ch, int pos, int s[2*HW], int n);
        model_frame(ch, pos, s, n);
        for (int i = 0; i < n; i++) begin
            int waitc = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'(s[i]);
            // ch/pos are only meaningful on the first sample; scramble the rest
            in_ch    = (i == 0) ? 1'(ch) : 1'($urandom);
            in_pos   = (i == 0) ? 2'(pos) : 2'($urandom);
            #1;
            while (!in_ready && waitc < 200) begin
                @(negedge clk);
                #1;
                waitc++;
                stall_cycles++;
            end
            if (!in_ready) chk("accept_timeout", 0, 1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (expq.size() != 0 && w < 500) begin
            @(negedge clk);
            #3;
            w++;
        end
        if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    endtask

    task automatic chk_seq(string name, int ex[2*HW], bit exl[2*HW], int n);
        chk({name, "_count"}, cap.size(), n);
        for (int i = 0; i < n && i < cap.size(); i++) begin
            chk({name, "_data"}, cap[i], ex[i]);
            chk({name, "_last"}, int'(capl[i]), int'(exl[i]));
        end
        cap.delete();
        capl.delete();
    endtask

    // Output checker: every handshake is matched against the model queue.
    initial begin
        exp_t                e;
        logic signed [W-1:0] prev_d = '0;
        bit                  prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) chk("hold_data", int'(out_data), int'(prev_d));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output", int'(out_data), -99999);
                end else begin
                    e = expq.pop_front();
                    chk("out_data", int'(out_data), e.data);
                    chk("out_ch", int'(out_ch), e.ch);
                    chk("out_last", int'(out_last), int'(e.last));
                    chk("sat", int'(sat), int'(e.sat));
                    if (e.flush) chk("flush_in_ready", int'(in_ready), 0);
                    cap.push_back(int'(out_data));
                    capl.push_back(out_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
        end
    end

    // Random downstream backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[2*HW];
        logic signed [W-1:0] r;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        model_reset();

        send(0, 1, '{1, 2, 3, 4, 5, 6, 7, 8}, 8);
        wait_drain();
        chk_seq("first_frame", '{1, 2, 3, 4, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        stall_cycles = 0;
        send(0, 0, '{10, 10, 10, 10, 0, 0, 0, 0}, 8);
        chk("middle_throughput_stalls", stall_cycles, 0);
        wait_drain();
        chk_seq("middle_frame", '{15, 16, 17, 18, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        send(0, 0, '{0, 0, 0, 0, 32767, 32767, 32767, 32767}, 8);
        send(0, 0, '{100, 100, 100, 100, -32768, -32768, -32768, -32768}, 8);
        wait_drain();
        chk_seq("sat_pos", '{0, 0, 0, 0, 32767, 32767, 32767, 32767},
                '{0, 0, 0, 1, 0, 0, 0, 1}, 8);
        chk("sat_sticky", int'(sat), 1);
        send(0, 0, '{-1, -1, -1, -1, 0, 0, 0, 0}, 8);
        wait_drain();
        chk_seq("sat_neg", '{-32768, -32768, -32768, -32768, 0, 0, 0, 0},
                '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        send(1, 2, '{1, 2, 3, 4, 5, 6, 7, 8}, 8);
        wait_drain();
        chk_seq("last_frame", '{1, 2, 3, 4, 5, 6, 7, 8}, '{0, 0, 0, 0, 0, 0, 0, 1}, 8);
        send(1, 0, '{1, 1, 1, 1, 0, 0, 0, 0}, 8);
        wait_drain();
        chk_seq("after_flush", '{1, 1, 1, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        fork
            send(0, 0, '{20, 21, 22, 23, 5, 5, 5, 5}, 8);
            begin
                int w = 0;
                while (cap.size() < 2 && w < 100) begin
                    @(negedge clk);
                    #3;
                    w++;
                end
                @(negedge clk);
                out_ready = 1'b0;
                repeat (5) begin
                    #1;
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_out_valid", int'(out_valid), 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk_seq("backpressure", '{20, 21, 22, 23, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        send(0, 0, '{1, 1, 1, 0, 0, 0, 0, 0}, 3);
        out_ready = 1'b0;
        rst       = 1'b1;
        chk_seq("pre_reset", '{6, 6, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 2);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_last", int'(out_last), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_sat", int'(sat), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        model_reset();
        send(0, 0, '{7, 7, 7, 7, 0, 0, 0, 0}, 8);
        wait_drain();
        chk_seq("post_reset", '{7, 7, 7, 7, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0}, 4);

        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 2*HW; i++) begin
                if ($urandom_range(0, 3) == 0)
                    s[i] = $urandom_range(0, 1) ? 32767 - int'($urandom_range(0, 50))
                                                : -32768 + int'($urandom_range(0, 50));
                else begin
                    r    = W'($urandom);
                    s[i] = int'(r);
                end
            end
            send(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), s, 8);
        end
        wait_drain();
        rnd_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/overlap_add_stream.md
# overlap_add_stream

Streaming, parametrised overlap/add stage for the MPEG-2 AAC decoder. It sits between the windowed IMDCT output and the PCM output path. It accepts one 2·HALF_WINDOW-sample frame per channel, sample by sample. The first half of each frame is added, with saturation, to the stored second half of that channel's previous frame and emitted as PCM. The second half is kept in a per-channel history buffer. Frames at the first or last position of a sequence get dedicated start and flush behaviour.

## Interface
- HALF_WINDOW, 512, samples per half window (power of two, ≥2)
- WORD, 16, signed sample width in bits
- CHANNELS, 2, independent channel histories (≥1)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts input this cycle
- in_data  in  WORD  signed windowed IMDCT sample
- in_ch  in  max(1,$clog2(CHANNELS))  channel; sampled with first sample of frame only
- in_pos  in  2  sequence position (0 middle, 1 first, 2 last, 3 treated as middle); sampled with first sample only
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  WORD  signed PCM sample
- out_ch  out  same as in_ch  channel of out_data
- out_last  out  1  marks final output sample of a frame (including flush)
- sat  out  1  sticky: any addition saturated since reset

## Operation
- Storage: history array of CHANNELS×HALF_WINDOW words, addressed ch·HALF_WINDOW+k, with combinational read. Per-channel hist_valid bit; an invalid history reads as zero.
- States:
  - IDLE: first input handshake latches ch/pos, processes sample k=0 as ADD, then goes to ADD.
  - ADD: for k<HALF_WINDOW, output = sat(in_data + hist) (hist forced to 0 if pos=first or !hist_valid[ch]). After k=HALF_WINDOW-1, go to STORE with k=0.
  - STORE: each accepted sample is written to hist[ch][k]; no output. After k=HALF_WINDOW-1, set hist_valid[ch]. Then go to FLUSH if pos=last, else IDLE.
  - FLUSH: in_ready=0; emits hist[ch][k], unmodified, for k=0..HALF_WINDOW-1; out_last on k=HALF_WINDOW-1. On that handshake, clear hist_valid[ch] and go to IDLE.
- out_last is set on the final ADD output only when pos≠last.
- Saturation: sum computed in WORD+1 bits and clamped to [−2^(WORD−1), 2^(WORD−1)−1]. Any clamp sets sat.
- in_ready:
  - IDLE and ADD: (!out_valid || out_ready).
  - STORE: 1.
  - FLUSH: 0.
- Output register holds value while out_valid && !out_ready.
- Frames of different channels may be interleaved only at frame boundaries.

## Timing
- Reset values: state IDLE, k=0, all hist_valid=0, in_ready=0 during the rst cycle, out_valid=0, out_data=0, out_ch=0, out_last=0, sat=0. The history array contents are not reset.
- Latency: ADD output is registered on the cycle after the input handshake. FLUSH output follows one cycle after entry and then one per handshake.
- Throughput:
  - Middle/first frame: 2·HALF_WINDOW cycles with no backpressure.
  - Last frame: 3·HALF_WINDOW cycles plus 1.
- Backpressure in ADD stalls input with no loss. STORE never stalls.
- rst mid-frame: the frame is abandoned, all histories are invalidated, and the next accepted sample starts a new frame.
- A frame with pos=last immediately followed by pos=first on the same channel: the new frame sees zero history.

## Structure
- Package overlap_pkg:
  - seq_pos_t enum (MIDDLE=0, FIRST=1, LAST=2).
  - state_t enum (IDLE, ADD, STORE, FLUSH).
  - Constants for saturation bounds derived from WORD.
- Sub-module overlap_sat_add: combinational WORD-bit signed saturating adder with a sat flag. It is instantiated once in the ADD datapath.
- The top holds the FSM, counter k, history array, hist_valid bits and output register.

## Test plan
All scenarios use HALF_WINDOW=4, WORD=16, CHANNELS=2.
- Frame pos=first on ch0 with samples 1..8 -> outputs 1,2,3,4 with out_last on 4; hist_valid[0]=1.
- Next ch0 frame, pos=middle, samples 10,10,10,10,0,0,0,0 -> outputs 15,16,17,18; history becomes zeros.
- ch0 history 32767×4, then middle frame first half 100×4 -> outputs 32767×4 and sat=1. Repeat with −32768 history and −1 input -> outputs −32768.
- ch1 frame pos=last with samples 1..8, no prior history -> outputs 1,2,3,4 (no out_last), then flush 5,6,7,8 with out_last on 8; in_ready=0 during flush; hist_valid[1]=0 afterwards.
- out_ready held low for 5 cycles mid-ADD -> out_data stable, in_ready=0, no sample lost or duplicated; STORE samples are accepted at 1/cycle regardless.
- rst asserted after 3 ADD samples on ch0 -> outputs cleared next cycle; a following middle frame with samples 7×4 outputs 7×4 (history zero).
